// File: rtl/mdu_ctrl_if.sv
// E-stage / hazard-unit side of the multiply/divide unit.
// master drives the operation request, slave is the MDU controller.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_req;

    modport master (
        output start, op, a, b, md_use_D,
        input  hi, lo, busy, done, stall_req
    );

    modport slave (
        input  start, op, a, b, md_use_D,
        output hi, lo, busy, done, stall_req
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO and runs a fixed-length
// busy window per MULT/DIV before committing the captured result.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_ctrl_if.slave  md
);

    localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;
    logic        done_q, done_d;

    logic        is_md;
    logic        is_mthi;
    logic        is_mtlo;
    logic        is_div;
    logic        sgn;
    logic        busy;

    assign is_md   = ~md.op[2];
    assign is_mthi = md.op == 3'b100;
    assign is_mtlo = md.op == 3'b101;
    assign is_div  = md.op[1];
    assign sgn     = ~md.op[0];
    assign busy    = state_q == RUN;

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    assign a_ext = {{32{sgn & md.a[31]}}, md.a};
    assign b_ext = {{32{sgn & md.b[31]}}, md.b};
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN, rem 0.
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_neg  = sgn & md.a[31];
    assign b_neg  = sgn & md.b[31];
    assign b_zero = md.b == 32'd0;
    assign a_mag  = a_neg ? -md.a : md.a;
    assign b_mag  = b_neg ? -md.b : md.b;
    assign b_safe = b_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md.start) begin
                    unique case (1'b1)
                        is_md: begin
                            state_d = RUN;
                            if (is_div) begin
                                cnt_d     = DIV_N;
                                pend_hi_d = rem;
                                pend_lo_d = quot;
                                pend_we_d = ~b_zero;
                            end else begin
                                cnt_d     = MUL_N;
                                pend_hi_d = prod[63:32];
                                pend_lo_d = prod[31:0];
                                pend_we_d = 1'b1;
                            end
                        end
                        is_mthi: hi_d = md.a;
                        is_mtlo: lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            done_q    <= done_d;
        end
    end

    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.busy      = busy;
    assign md.done      = done_q;
    assign md.stall_req = md.md_use_D & (busy | (md.start & is_md));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed checks of mdu_ctrl timing, HI/LO results and stall.
// Expected values are hand-computed constants.
module tb_mdu_ctrl;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .md     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the done cycle.
    task automatic do_op(input string       tag,
                         input logic [2:0]  op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int          n,
                         input logic [31:0] old_hi,
                         input logic [31:0] old_lo,
                         input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo,
                         input logic        use_d,
                         input logic        poke);
        int cnt;
        cnt = 0;
        bus.md_use_D = use_d;
        bus.start    = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        chk({tag, "_stall_start"}, 32'(bus.stall_req), 32'(use_d));
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            if (poke && i == 1) begin
                bus.start = 1'b1;
                bus.op    = 3'b100;
                bus.a     = 32'h0000_0055;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            chk({tag, "_hold_hi"}, bus.hi, old_hi);
            chk({tag, "_hold_lo"}, bus.lo, old_lo);
            chk({tag, "_stall_busy"}, 32'(bus.stall_req), 32'(use_d));
            chk({tag, "_done_in_busy"}, 32'(bus.done), 32'd0);
            cnt++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hi"}, bus.hi, exp_hi);
        chk({tag, "_lo"}, bus.lo, exp_lo);
        chk({tag, "_stall_done"}, 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        bus.md_use_D = 1'b0;
    endtask

    initial begin
        logic seen;
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 3'b000;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        bus.md_use_D = 1'b0;
        reset_n      = 1'b1;

        // Load HI/LO, start a MULT, then reset it mid-flight.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hAAAA_5555;
        @(negedge clk);
        chk("pre_mthi", bus.hi, 32'hAAAA_5555);
        bus.op = 3'b101;
        bus.a  = 32'h5555_AAAA;
        @(negedge clk);
        chk("pre_mtlo", bus.lo, 32'h5555_AAAA);
        bus.op = 3'b000;
        bus.a  = 32'd3;
        bus.b  = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_hi", bus.hi, 32'd0);
        chk("mid_rst_lo", bus.lo, 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        chk("mid_rst_hi_after", bus.hi, 32'd0);

        do_op("mult", 3'b000, 32'd3, 32'hFFFF_FFFE, 5,
              32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        do_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
              32'hFFFF_FFFF, 32'hFFFF_FFFA,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        do_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10,
              32'hFFFF_FFFE, 32'h0000_0001,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
        do_op("divu_z", 3'b011, 32'd7, 32'd0, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFFD,
              32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op("divu_poke", 3'b011, 32'd100, 32'd7, 10,
              32'h0000_0000, 32'h8000_0000,
              32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);

        // Back-to-back MTHI/MTLO with MFHI-style use in D: no stall.
        bus.md_use_D = 1'b1;
        bus.start    = 1'b1;
        bus.op       = 3'b100;
        bus.a        = 32'h1234_5678;
        #1;
        chk("mthi_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_lo", bus.lo, 32'h0000_000E);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        chk("mthi_done", 32'(bus.done), 32'd0);
        bus.op = 3'b101;
        bus.a  = 32'h9ABC_DEF0;
        @(negedge clk);
        chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", bus.hi, 32'h1234_5678);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
        chk("mtlo_done", 32'(bus.done), 32'd0);

        // Reserved op must leave everything alone.
        bus.op = 3'b110;
        bus.a  = 32'hDEAD_BEEF;
        bus.b  = 32'd3;
        #1;
        chk("rsv_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("rsv_hi", bus.hi, 32'h1234_5678);
        chk("rsv_lo", bus.lo, 32'h9ABC_DEF0);
        chk("rsv_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("rsv_done", 32'(bus.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
